// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types, widths and address-wrap helper for the SPI
//               slave register file.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } spi_state_e;

    localparam int CMD_RW_BIT = 7;
    localparam int ADDR_W     = 7;
    localparam int BYTE_W     = 8;

    // Burst address step: wraps to 0 after the last implemented register.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input int              num_regs);
        if (int'(addr) >= num_regs - 1) begin
            next_addr = '0;
        end else begin
            next_addr = addr + 7'd1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_regbank.sv
`default_nettype none
// ============================================================================
// Module      : spi_regbank
// Description : Byte register array with read-only ID at address 0, one write
//               port, combinational read port and flattened contents output.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_regbank
    import spi_pkg::*;
#(
    parameter int                NUM_REGS = 16,
    parameter logic [BYTE_W-1:0] ID_VALUE = 8'hA5
) (
    input  logic                       sclk,
    input  logic                       rst_n,
    input  logic                       i_wr_en,
    input  logic [ADDR_W-1:0]          i_wr_addr,
    input  logic [BYTE_W-1:0]          i_wr_data,
    input  logic [ADDR_W-1:0]          i_rd_addr,
    output logic [BYTE_W-1:0]          o_rd_data,
    output logic [NUM_REGS*BYTE_W-1:0] o_regs
);

    logic [NUM_REGS-1:0][BYTE_W-1:0] w_regs;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_id
                assign w_regs[gi] = ID_VALUE;
            end else begin : g_rw
                logic [BYTE_W-1:0] r_val;
                always_ff @(posedge sclk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_val <= '0;
                    end else if (i_wr_en && (i_wr_addr == ADDR_W'(gi))) begin
                        r_val <= i_wr_data;
                    end
                end
                assign w_regs[gi] = r_val;
            end
        end
    endgenerate

    assign o_regs = w_regs;

    // Addresses beyond the bank match no entry and read back as zero.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_addr == ADDR_W'(i)) begin
                o_rd_data = w_regs[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_regfile
// Description : SPI slave decoding command+data frames into register bank
//               reads/writes with auto-incrementing bursts, sclk domain only.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int                NUM_REGS = 16,
    parameter logic [BYTE_W-1:0] ID_VALUE = 8'hA5
) (
    input  logic                       sclk,
    input  logic                       rst_n,
    input  logic                       cs_n,
    input  logic                       mosi,
    output logic                       miso,
    output logic [NUM_REGS*BYTE_W-1:0] regs_o,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [BYTE_W-1:0]          wr_data,
    output logic                       addr_err
);

    localparam logic [ADDR_W:0] c_num_regs = (ADDR_W+1)'(NUM_REGS);

    spi_state_e        r_state;
    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_shift;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [6:0]        r_tx;

    logic              w_last;
    logic [BYTE_W-1:0] w_byte;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [ADDR_W-1:0] w_inc_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [BYTE_W-1:0] w_rd_data;
    logic              w_rd_valid;
    logic              w_addr_valid;
    logic              w_wr_en;

    assign w_last       = (r_bit_cnt == 3'd7);
    assign w_byte       = {r_shift, mosi};
    assign w_cmd_addr   = {r_shift[5:0], mosi};
    assign w_inc_addr   = next_addr(r_addr, NUM_REGS);
    // Next read byte: address straight from the wire at command end, else the stepped address.
    assign w_rd_addr    = (r_state == CMD) ? w_cmd_addr : w_inc_addr;
    assign w_rd_valid   = ({1'b0, w_rd_addr} < c_num_regs);
    assign w_addr_valid = ({1'b0, r_addr} < c_num_regs);
    assign w_wr_en      = !cs_n && (r_state == DATA) && w_last && !r_rw
                          && w_addr_valid && (r_addr != '0);

    spi_regbank #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_addr),
        .i_wr_data (w_byte),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data),
        .o_regs    (regs_o)
    );

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_addr    <= '0;
            r_rw      <= 1'b0;
            r_tx      <= '0;
            miso      <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            addr_err  <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            if (cs_n) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                miso      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_shift   <= {6'd0, mosi};
                        r_bit_cnt <= 3'd1;
                        addr_err  <= 1'b0;
                        miso      <= 1'b0;
                        r_state   <= CMD;
                    end
                    CMD: begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last) begin
                            r_rw      <= r_shift[CMD_RW_BIT-1];
                            r_addr    <= w_cmd_addr;
                            r_bit_cnt <= '0;
                            r_state   <= DATA;
                            if (r_shift[CMD_RW_BIT-1]) begin
                                miso <= w_rd_data[7];
                                r_tx <= w_rd_data[6:0];
                                if (!w_rd_valid) addr_err <= 1'b1;
                            end else begin
                                miso <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last) begin
                            r_addr <= w_inc_addr;
                            if (r_rw) begin
                                miso <= w_rd_data[7];
                                r_tx <= w_rd_data[6:0];
                                if (!w_rd_valid) addr_err <= 1'b1;
                            end else begin
                                miso <= 1'b0;
                                if (!w_addr_valid) begin
                                    addr_err <= 1'b1;
                                end else if (r_addr != '0) begin
                                    wr_pulse <= 1'b1;
                                    wr_addr  <= r_addr;
                                    wr_data  <= w_byte;
                                end
                            end
                        end else if (r_rw) begin
                            miso <= r_tx[6];
                            r_tx <= {r_tx[5:0], 1'b0};
                        end else begin
                            miso <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
